lfsr_gen: RTL and testbench

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_pkg.sv | 41 ++++
 rtl/lfsr_gen_if.sv | 24 ++
 rtl/lfsr_next.sv | 29 ++
 rtl/lfsr_gen.sv | 89 ++++++++
 tb/tb_lfsr_gen.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR types and primitive polynomial masks
package lfsr_pkg;

    typedef enum logic {
        FIBONACCI = 1'b0,
        GALOIS    = 1'b1
    } lfsr_mode_e;

    // Masks omit the implicit x^WIDTH term; every entry is a primitive polynomial.
    localparam logic [31:0] POLY_3  = 32'h0000_0003;
    localparam logic [31:0] POLY_4  = 32'h0000_0003;
    localparam logic [31:0] POLY_5  = 32'h0000_0005;
    localparam logic [31:0] POLY_6  = 32'h0000_0003;
    localparam logic [31:0] POLY_7  = 32'h0000_0003;
    localparam logic [31:0] POLY_8  = 32'h0000_001D;
    localparam logic [31:0] POLY_9  = 32'h0000_0021;
    localparam logic [31:0] POLY_10 = 32'h0000_0009;
    localparam logic [31:0] POLY_11 = 32'h0000_0005;
    localparam logic [31:0] POLY_12 = 32'h0000_0053;
    localparam logic [31:0] POLY_13 = 32'h0000_001B;
    localparam logic [31:0] POLY_14 = 32'h0000_002B;
    localparam logic [31:0] POLY_15 = 32'h0000_0003;
    localparam logic [31:0] POLY_16 = 32'h0000_002D;
    localparam logic [31:0] POLY_17 = 32'h0000_0009;
    localparam logic [31:0] POLY_18 = 32'h0000_0081;
    localparam logic [31:0] POLY_19 = 32'h0000_0027;
    localparam logic [31:0] POLY_20 = 32'h0000_0009;
    localparam logic [31:0] POLY_21 = 32'h0000_0005;
    localparam logic [31:0] POLY_22 = 32'h0000_0003;
    localparam logic [31:0] POLY_23 = 32'h0000_0021;
    localparam logic [31:0] POLY_24 = 32'h0000_0087;
    localparam logic [31:0] POLY_25 = 32'h0000_0009;
    localparam logic [31:0] POLY_26 = 32'h0000_0047;
    localparam logic [31:0] POLY_27 = 32'h0000_0027;
    localparam logic [31:0] POLY_28 = 32'h0000_0009;
    localparam logic [31:0] POLY_29 = 32'h0000_0005;
    localparam logic [31:0] POLY_30 = 32'h0000_0053;
    localparam logic [31:0] POLY_31 = 32'h0000_0009;
    localparam logic [31:0] POLY_32 = 32'h0040_0007;

endpackage

// File: rtl/lfsr_gen_if.sv
// rtl/lfsr_gen_if.sv - control and observation bundle for lfsr_gen
interface lfsr_gen_if #(
    parameter int WIDTH = 9
);
    logic             load;
    logic [WIDTH-1:0] seed_in;
    logic             en;
    logic [WIDTH-1:0] state;
    logic             bit_out;
    logic             wrap;
    logic [WIDTH-1:0] period;
    logic             period_valid;
    logic             lockup;

    modport master (
        output load, seed_in, en,
        input  state, bit_out, wrap, period, period_valid, lockup
    );

    modport slave (
        input  load, seed_in, en,
        output state, bit_out, wrap, period, period_valid, lockup
    );
endinterface

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational one-step LFSR advance
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_9),
    parameter lfsr_mode_e       MODE  = FIBONACCI
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    if (MODE == GALOIS) begin : g_galois
        assign next = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? POLY : '0);
    end else begin : g_fibonacci
        logic fb;

        // The x^WIDTH term taps the top bit; POLY[k] taps the bit that feeds position k.
        always_comb begin
            fb = state[WIDTH-1];
            for (int k = 1; k < WIDTH; k++) begin
                fb = fb ^ (POLY[k] & state[k-1]);
            end
        end

        assign next = {state[WIDTH-2:0], fb};
    end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - LFSR sequence generator with period measurement
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 9,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_9),
    parameter lfsr_mode_e       MODE  = FIBONACCI,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic       clk,
    input  logic       rst_n,
    lfsr_gen_if.slave  bus
);

    if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be within 3..32");
    end
    if (POLY[0] == 1'b0) begin : g_bad_poly
        $error("lfsr_gen: POLY[0] must be 1");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             period_valid_q;
    logic             wrap_q;
    logic             lockup_q;
    logic [WIDTH-1:0] next_state;

    lfsr_next #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .MODE  (MODE)
    ) u_next (
        .state (state_q),
        .next  (next_state)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= SEED;
            ref_q          <= SEED;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
            lockup_q       <= 1'b0;
        end else begin
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
            if (bus.load) begin
                // A zero seed would freeze the register, so SEED is substituted
                // and the substitution restarts the measurement like any load.
                if (bus.seed_in == '0) begin
                    state_q  <= SEED;
                    ref_q    <= SEED;
                    lockup_q <= 1'b1;
                end else begin
                    state_q <= bus.seed_in;
                    ref_q   <= bus.seed_in;
                end
                cnt_q          <= '0;
                period_valid_q <= 1'b0;
            end else if (bus.en) begin
                state_q <= next_state;
                if (next_state == ref_q) begin
                    wrap_q         <= 1'b1;
                    period_q       <= cnt_q + 1'b1;
                    period_valid_q <= 1'b1;
                    cnt_q          <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.state        = state_q;
    assign bus.bit_out      = state_q[WIDTH-1];
    assign bus.wrap         = wrap_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.lockup       = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - scoreboard bench for four lfsr_gen configurations
module tb_lfsr_gen;
    import lfsr_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       en;
    logic [8:0] seed9;
    logic [3:0] seed4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(9)) if0 ();
    lfsr_gen_if #(.WIDTH(9)) if1 ();
    lfsr_gen_if #(.WIDTH(4)) if2 ();
    lfsr_gen_if #(.WIDTH(4)) if3 ();

    assign if0.load = load;  assign if0.en = en;  assign if0.seed_in = seed9;
    assign if1.load = load;  assign if1.en = en;  assign if1.seed_in = seed9;
    assign if2.load = load;  assign if2.en = en;  assign if2.seed_in = seed4;
    assign if3.load = load;  assign if3.en = en;  assign if3.seed_in = seed4;

    lfsr_gen #(.WIDTH(9), .POLY(9'h021), .MODE(FIBONACCI), .SEED(9'd1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    lfsr_gen #(.WIDTH(9), .POLY(9'h021), .MODE(GALOIS), .SEED(9'd1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    lfsr_gen #(.WIDTH(4), .POLY(4'h3), .MODE(FIBONACCI), .SEED(4'd1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    lfsr_gen #(.WIDTH(4), .POLY(4'h3), .MODE(GALOIS), .SEED(4'd1))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic [31:0] a_st[4];
    logic [31:0] a_per[4];
    logic        a_bo[4];
    logic        a_wrap[4];
    logic        a_lock[4];
    logic        a_pv[4];

    assign a_st[0] = 32'(if0.state);  assign a_per[0] = 32'(if0.period);
    assign a_st[1] = 32'(if1.state);  assign a_per[1] = 32'(if1.period);
    assign a_st[2] = 32'(if2.state);  assign a_per[2] = 32'(if2.period);
    assign a_st[3] = 32'(if3.state);  assign a_per[3] = 32'(if3.period);
    assign a_bo[0] = if0.bit_out;  assign a_wrap[0] = if0.wrap;  assign a_lock[0] = if0.lockup;  assign a_pv[0] = if0.period_valid;
    assign a_bo[1] = if1.bit_out;  assign a_wrap[1] = if1.wrap;  assign a_lock[1] = if1.lockup;  assign a_pv[1] = if1.period_valid;
    assign a_bo[2] = if2.bit_out;  assign a_wrap[2] = if2.wrap;  assign a_lock[2] = if2.lockup;  assign a_pv[2] = if2.period_valid;
    assign a_bo[3] = if3.bit_out;  assign a_wrap[3] = if3.wrap;  assign a_lock[3] = if3.lockup;  assign a_pv[3] = if3.period_valid;

    int          cfg_w[4]    = '{9, 9, 4, 4};
    logic [31:0] cfg_poly[4] = '{32'h21, 32'h21, 32'h3, 32'h3};
    bit          cfg_gal[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic [31:0] st;
        logic        bo;
        logic        wrap;
        logic        lock;
        logic [31:0] per;
        logic        pv;
    } exp_t;

    typedef struct {
        exp_t d[4];
    } exp4_t;

    exp4_t sb[$];
    exp4_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int wraps[4] = '{0, 0, 0, 0};

    logic [31:0] m_st[4];
    logic [31:0] m_ref[4];
    logic [31:0] m_cnt[4];
    logic [31:0] m_per[4];
    logic        m_pv[4];

    logic [31:0] fib_tab[5] = '{32'h002, 32'h004, 32'h008, 32'h010, 32'h021};
    logic [31:0] gal_tab[9] = '{32'h002, 32'h004, 32'h008, 32'h010, 32'h020,
                                32'h040, 32'h080, 32'h100, 32'h021};

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference arithmetic: Galois is multiplication by x modulo P(x);
    // Fibonacci feeds back the parity of the tapped bits.
    function automatic logic [31:0] model_next(int w, logic [31:0] poly, bit gal, logic [31:0] s);
        longint unsigned t;
        longint unsigned mask;
        logic [31:0]     taps;
        int              fb;
        mask = (64'd1 << w) - 1;
        if (gal) begin
            t = longint'(s) * 2;
            if (t >= (64'd1 << w)) t = t ^ ((64'd1 << w) | longint'(poly));
            return 32'(t & mask);
        end
        taps = (poly >> 1) | (32'd1 << (w - 1));
        fb   = $countones(s & taps) % 2;
        return 32'((longint'(s) * 2 + longint'(fb)) & mask);
    endfunction

    function automatic void model_apply();
        exp4_t       e;
        logic [31:0] sd;
        logic        w_p;
        logic        l_p;
        for (int d = 0; d < 4; d++) begin
            w_p = 1'b0;
            l_p = 1'b0;
            sd  = (cfg_w[d] == 9) ? 32'(seed9) : 32'(seed4);
            if (!rst_n) begin
                m_st[d] = 1; m_ref[d] = 1; m_cnt[d] = 0; m_per[d] = 0; m_pv[d] = 1'b0;
            end else if (load) begin
                if (sd == 0) begin
                    m_st[d] = 1; m_ref[d] = 1; l_p = 1'b1;
                end else begin
                    m_st[d] = sd; m_ref[d] = sd;
                end
                m_cnt[d] = 0;
                m_pv[d]  = 1'b0;
            end else if (en) begin
                m_st[d]  = model_next(cfg_w[d], cfg_poly[d], cfg_gal[d], m_st[d]);
                m_cnt[d] = m_cnt[d] + 1;
                if (m_st[d] == m_ref[d]) begin
                    w_p = 1'b1; m_per[d] = m_cnt[d]; m_pv[d] = 1'b1; m_cnt[d] = 0;
                end
            end
            e.d[d].st   = m_st[d];
            e.d[d].bo   = m_st[d][cfg_w[d] - 1];
            e.d[d].wrap = w_p;
            e.d[d].lock = l_p;
            e.d[d].per  = m_per[d];
            e.d[d].pv   = m_pv[d];
        end
        sb.push_back(e);
    endfunction

    task automatic step(input bit r, input bit l, input bit e, input logic [8:0] s9, input logic [3:0] s4);
        rst_n = r; load = l; en = e; seed9 = s9; seed4 = s4;
        model_apply();
        @(negedge clk);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            for (int d = 0; d < 4; d++) begin
                check($sformatf("d%0d_state", d),   a_st[d],   mon_e.d[d].st);
                check($sformatf("d%0d_bit_out", d), 32'(a_bo[d]),   32'(mon_e.d[d].bo));
                check($sformatf("d%0d_wrap", d),    32'(a_wrap[d]), 32'(mon_e.d[d].wrap));
                check($sformatf("d%0d_lockup", d),  32'(a_lock[d]), 32'(mon_e.d[d].lock));
                check($sformatf("d%0d_pvalid", d),  32'(a_pv[d]),   32'(mon_e.d[d].pv));
                check($sformatf("d%0d_period", d),  a_per[d],  mon_e.d[d].per);
                check($sformatf("d%0d_nonzero", d), 32'(a_st[d] != 0), 32'd1);
                if (a_wrap[d]) wraps[d]++;
            end
        end
    end

    int w0;
    int w2;
    int w3;

    initial begin
        rst_n = 1'b0; load = 1'b0; en = 1'b0; seed9 = '0; seed4 = '0;
        for (int d = 0; d < 4; d++) begin
            m_st[d] = 1; m_ref[d] = 1; m_cnt[d] = 0; m_per[d] = 0; m_pv[d] = 1'b0;
        end
        @(negedge clk);

        repeat (3) step(1'b0, 1'b0, 1'b0, 9'h0, 4'h0);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_state%0d", d),  a_st[d], 32'd1);
            check($sformatf("rst_period%0d", d), a_per[d], 32'd0);
            check($sformatf("rst_pvalid%0d", d), 32'(a_pv[d]), 32'd0);
            check($sformatf("rst_pulses%0d", d), 32'({a_wrap[d], a_lock[d]}), 32'd0);
        end

        w0 = wraps[0]; w2 = wraps[2]; w3 = wraps[3];
        for (int k = 1; k <= 511; k++) begin
            step(1'b1, 1'b0, 1'b1, 9'h0, 4'h0);
            if (k <= 5) check($sformatf("fib_step%0d", k), a_st[0], fib_tab[k-1]);
            if (k <= 9) check($sformatf("gal_step%0d", k), a_st[1], gal_tab[k-1]);
            if (k == 15) begin
                check("w4_fib_first_wrap", {a_per[2][30:0], a_wrap[2]}, {31'd15, 1'b1});
                check("w4_gal_first_wrap", {a_per[3][30:0], a_wrap[3]}, {31'd15, 1'b1});
            end
            if (k == 510) check("fib_no_early_wrap", 32'(a_wrap[0]), 32'd0);
        end
        check("fib_wrap_511",   32'(a_wrap[0]), 32'd1);
        check("gal_wrap_511",   32'(a_wrap[1]), 32'd1);
        check("fib_period_511", a_per[0], 32'd511);
        check("gal_period_511", a_per[1], 32'd511);
        check("fib_pvalid",     32'(a_pv[0]), 32'd1);
        check("fib_wrap_count", 32'(wraps[0] - w0), 32'd1);
        check("w4_fib_wraps",   32'(wraps[2] - w2), 32'd34);
        check("w4_gal_wraps",   32'(wraps[3] - w3), 32'd34);

        step(1'b1, 1'b1, 1'b0, 9'h0, 4'h0);
        check("lockup_state9", a_st[0], 32'd1);
        check("lockup_pulse9", 32'(a_lock[0]), 32'd1);
        check("lockup_state4", a_st[2], 32'd1);
        check("lockup_pulse4", 32'(a_lock[3]), 32'd1);
        step(1'b1, 1'b0, 1'b1, 9'h0, 4'h0);
        check("lockup_one_cycle", 32'(a_lock[0]), 32'd0);
        repeat (510) step(1'b1, 1'b0, 1'b1, 9'h0, 4'h0);
        check("lockup_full_period", a_per[0], 32'd511);

        step(1'b1, 1'b1, 1'b1, 9'h0AB, 4'hB);
        check("load_en_fib", a_st[0], 32'h0AB);
        check("load_en_gal", a_st[1], 32'h0AB);
        check("load_en_w4",  a_st[2], 32'hB);
        check("load_pvalid", 32'(a_pv[0]), 32'd0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 9'h0, 4'h0);
        check("hold_fib", a_st[0], 32'h0AB);
        check("hold_w4",  a_st[3], 32'hB);
        repeat (511) step(1'b1, 1'b0, 1'b1, 9'h0, 4'h0);
        check("load_no_step_counted", {a_per[0][30:0], a_wrap[0]}, {31'd511, 1'b1});

        repeat (200) step(1'b1, 1'b0, 1'b1, 9'h0, 4'h0);
        step(1'b0, 1'b0, 1'b1, 9'h0, 4'h0);
        check("midrst_state",  a_st[0], 32'd1);
        check("midrst_pvalid", 32'(a_pv[0]), 32'd0);
        repeat (511) step(1'b1, 1'b0, 1'b1, 9'h0, 4'h0);
        check("midrst_period", a_per[0], 32'd511);
        check("midrst_wrap",   32'(a_wrap[0]), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 7,
                 ($urandom_range(0, 3) == 0) ? 9'h0 : 9'($urandom),
                 ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom));
        end
        step(1'b1, 1'b0, 1'b0, 9'h0, 4'h0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
